// File: rtl/tsp_perm_solver.sv
// tsp_perm_solver: exhaustive Manhattan TSP over N_CITIES points using iterative Heap permutations (optional LED tour display under TSP_LED_SHOW_EN).
module tsp_perm_solver #(
    parameter int N_CITIES = 6,
    parameter int COORD_W  = 16,
    parameter int DISP_DIV = 13500000,
    localparam int IDX_W   = $clog2(N_CITIES),
    localparam int COST_W  = COORD_W + 1 + $clog2(N_CITIES)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [COST_W-1:0]  best_cost,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [IDX_W-1:0]   rd_city,
    output logic [5:0]         led
);
    localparam int M = N_CITIES - 1;
    localparam logic [IDX_W:0] NC = (IDX_W+1)'(N_CITIES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CITIES - 1);
    localparam logic [IDX_W-1:0] MLAST = IDX_W'(M - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EVAL, S_CMP, S_PERM, S_DONE} state_t;
    state_t state;

    logic [COORD_W-1:0] xs [N_CITIES];
    logic [COORD_W-1:0] ys [N_CITIES];
    logic [IDX_W-1:0]   perm [N_CITIES];
    logic [IDX_W-1:0]   best_tour [N_CITIES];
    logic [IDX_W-1:0]   c [M];
    logic [IDX_W-1:0]   k, kn, i, sa, sb;
    logic [COST_W-1:0]  acc;
    logic [COORD_W-1:0] xa, xb, ya, yb;
    logic [COORD_W:0]   d;

    always_comb begin
        kn = (k == LAST) ? '0 : k + 1'b1;
        xa = xs[perm[k]];
        xb = xs[perm[kn]];
        ya = ys[perm[k]];
        yb = ys[perm[kn]];
        d  = {1'b0, (xa > xb) ? xa - xb : xb - xa} + {1'b0, (ya > yb) ? ya - yb : yb - ya};
        sa = IDX_W'(1) + (i[0] ? c[i] : '0);
        sb = i + 1'b1;
    end

    assign rd_city = ({1'b0, rd_idx} < NC) ? best_tour[rd_idx] : '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            best_cost <= '0;
            acc       <= '0;
            k         <= '0;
            i         <= '0;
            for (int j = 0; j < N_CITIES; j++) begin
                xs[j]        <= '0;
                ys[j]        <= '0;
                perm[j]      <= IDX_W'(j);
                best_tour[j] <= IDX_W'(j);
            end
            for (int j = 0; j < M; j++) c[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_en && ({1'b0, wr_addr} < NC)) begin
                        xs[wr_addr] <= wr_x;
                        ys[wr_addr] <= wr_y;
                    end
                    if (start) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end
                end
                S_INIT: begin
                    for (int j = 0; j < N_CITIES; j++) perm[j] <= IDX_W'(j);
                    for (int j = 0; j < M; j++) c[j] <= '0;
                    i         <= '0;
                    k         <= '0;
                    acc       <= '0;
                    best_cost <= '1;
                    valid     <= 1'b0;
                    state     <= S_EVAL;
                end
                S_EVAL: begin
                    acc   <= acc + COST_W'(d);
                    k     <= kn;
                    state <= (k == LAST) ? S_CMP : S_EVAL;
                end
                S_CMP: begin
                    if (acc < best_cost) begin
                        best_cost <= acc;
                        for (int j = 0; j < N_CITIES; j++) best_tour[j] <= perm[j];
                    end
                    acc   <= '0;
                    state <= S_PERM;
                end
                S_PERM: begin
                    // Heap's algorithm on perm[1..N-1]; city 0 stays fixed as the tour start
                    if (c[i] < i) begin
                        perm[sa] <= perm[sb];
                        perm[sb] <= perm[sa];
                        c[i]     <= c[i] + 1'b1;
                        i        <= '0;
                        state    <= S_EVAL;
                    end else begin
                        c[i] <= '0;
                        if (i == MLAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            valid <= 1'b1;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TSP_LED_SHOW_EN
    localparam int DIV_W = $clog2(DISP_DIV + 1);
    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] pos;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !valid) begin
            div <= '0;
            pos <= '0;
        end else if (div == DIV_W'(DISP_DIV - 1)) begin
            div <= '0;
            pos <= (pos == LAST) ? '0 : pos + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign led = busy ? 6'b011111 : valid ? ~(6'b1 << best_tour[pos]) : 6'b111111;
`else
    logic unused_div;
    assign unused_div = (DISP_DIV == 0);
    assign led = ~{busy, valid, best_cost[3:0]};
`endif
endmodule
